// File: rtl/axi_lite_latency_mem_pkg.sv
// Shared definitions for axi_lite_latency_mem: response codes, channel FSM
// state encodings, latency counter width and stall-injection LFSR helpers.
package axi_lite_latency_mem_pkg;

  localparam int unsigned LAT_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/axi_lat_counter.sv
// Loadable down-counter with a registered done flag.
//   clk_i/rst_ni : clock, async active-low reset
//   load_i       : load load_val_i this cycle (takes priority over counting)
//   load_val_i   : value to load
//   done_o       : high while the count is zero
module axi_lat_counter
  import axi_lite_latency_mem_pkg::*;
#(
  parameter int unsigned W = LAT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q;

  // Count down to zero and hold there until reloaded
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/axi_lite_latency_mem.sv
// AXI4-Lite slave memory model with configurable base address, depth and
// independent read/write latencies. Out-of-range accesses answer SLVERR.
//   CLK, RSTn        : clock, async active-low reset
//   S_AXI_AW*/W*/B*  : write address, data and response channels
//   S_AXI_AR*/R*     : read address and data channels
// Optional macro AXI_MEM_STALL_INJECT_EN: a free-running LFSR randomly
// withholds AWREADY/WREADY/ARREADY to stress master stall handling.
// `mem` is not reset so it can be preloaded through the hierarchy.
module axi_lite_latency_mem
  import axi_lite_latency_mem_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned          RD_LATENCY = 2,
  parameter int unsigned          WR_LATENCY = 1
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  output logic [1:0]              S_AXI_BRESP,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned AW1    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // One extra bit so BASE_ADDR + 4*MEM_WORDS cannot wrap
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [AW1-1:0] ax, lo, hi;
    ax = {1'b0, a};
    lo = {1'b0, BASE_ADDR};
    hi = lo + AW1'(4 * MEM_WORDS);
    return (ax >= lo) && (ax < hi);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // READY suppression mask: bit 0 AW, bit 1 W, bit 2 AR
  logic [2:0] stall_c;
`ifdef AXI_MEM_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d  = lfsr_next(lfsr_q);
  // READY registers use the value lfsr_q will hold next cycle
  assign stall_c = lfsr_d[2:0];
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign stall_c = 3'b000;
`endif

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_load_c, w_commit_c, w_done, w_in_range_c;
  logic [IDX_W-1:0]      w_idx_c;

  assign w_in_range_c = in_range(awaddr_q);
  assign w_idx_c      = word_idx(awaddr_q);

  axi_lat_counter #(.W(LAT_W)) u_wr_cnt (
    .clk_i      (CLK),
    .rst_ni     (RSTn),
    .load_i     (w_load_c),
    .load_val_i (LAT_W'(WR_LATENCY)),
    .done_o     (w_done)
  );

  // Write FSM: collect AW and W in either order, wait, commit, respond
  always_comb begin
    w_state_d  = w_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    w_load_c   = 1'b0;
    w_commit_c = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          aw_got_d = 1'b1;
          awaddr_d = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && wready_q) begin
          w_got_d = 1'b1;
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
        end
        if (aw_got_d && w_got_d) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_load_c  = 1'b1;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_done) begin
          w_commit_c = w_in_range_c;
          bvalid_d   = 1'b1;
          bresp_d    = w_in_range_c ? RESP_OKAY : RESP_SLVERR;
          w_state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_got_d && !stall_c[0];
    wready_d  = (w_state_d == W_IDLE) && !w_got_d  && !stall_c[1];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Byte-lane commit; a same-cycle read sample still sees the old word
  always_ff @(posedge CLK) begin
    if (w_commit_c) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) mem[w_idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  r_load_c, r_done, r_in_range_c;
  logic [IDX_W-1:0]      r_idx_c;

  assign r_in_range_c = in_range(araddr_q);
  assign r_idx_c      = word_idx(araddr_q);

  axi_lat_counter #(.W(LAT_W)) u_rd_cnt (
    .clk_i      (CLK),
    .rst_ni     (RSTn),
    .load_i     (r_load_c),
    .load_val_i (LAT_W'(RD_LATENCY)),
    .done_o     (r_done)
  );

  // Read FSM: accept AR, wait, sample memory, hold response until RREADY
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_load_c  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          araddr_d  = S_AXI_ARADDR;
          r_load_c  = 1'b1;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_done) begin
          rvalid_d  = 1'b1;
          rdata_d   = r_in_range_c ? mem[r_idx_c] : '0;
          rresp_d   = r_in_range_c ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE) && !stall_c[2];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_latency_mem.sv
// Directed plus randomized bench for axi_lite_latency_mem against a
// word-array reference model of the memory and its address window.
module tb_axi_lite_latency_mem;

  localparam int unsigned MEM_WORDS = 64;
  localparam logic [31:0] BASE      = 32'h0000_0100;
  localparam int          RD_LAT    = 2;
  localparam int          WR_LAT    = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] model [MEM_WORDS];

  always #5 clk = ~clk;

  axi_lite_latency_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_WORDS  (MEM_WORDS),
    .BASE_ADDR  (BASE),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .CLK           (clk),
    .RSTn          (rst_n),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---- reference model: address window and byte-masked word store ----
  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * longint'(MEM_WORDS));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_rng(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return in_rng(a) ? model[widx(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (in_rng(a)) model[widx(a)] = (model[widx(a)] & ~mask) | (d & mask);
  endtask

  // ---- bus-level tasks (inputs driven 1 time unit after the rising edge) ----
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_start, input int w_start,
                           input int bdelay, output logic [1:0] resp);
    int t, n;
    bit aw_done, w_done, hs_aw, hs_w;
    logic [1:0] r0;
    t = 0; aw_done = 0; w_done = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && t < 100) begin
      awvalid = !aw_done && (t >= aw_start);
      wvalid  = !w_done && (t >= w_start);
      if (w_done && !aw_done) check("wready_low_while_aw_pending", wready, 0);
      if (aw_done && !w_done) check("awready_low_while_w_pending", awready, 0);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge clk); #1; t++;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_w_handshake", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bvalid && n < 100) begin
      check("wr_ready_busy", {awready, wready}, 2'b00);
      @(posedge clk); #1; n++;
    end
    check("wr_latency", n, WR_LAT + 1);
    r0 = bresp;
    repeat (bdelay) begin
      @(posedge clk); #1;
      check("bvalid_held", bvalid, 1);
      check("bresp_stable", bresp, r0);
    end
    resp = r0;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_drop", bvalid, 0);
    check("wr_ready_after_b", {awready, wready}, 2'b11);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_start, input int rdelay,
                          output logic [31:0] data, output logic [1:0] resp);
    int t, n;
    bit done, hs;
    logic [31:0] d0;
    logic [1:0] r0;
    t = 0; done = 0;
    araddr = addr;
    while (!done && t < 100) begin
      arvalid = (t >= ar_start);
      hs = arvalid && arready;
      @(posedge clk); #1; t++;
      if (hs) done = 1;
    end
    arvalid = 1'b0;
    check("ar_handshake", done, 1);
    n = 0;
    while (!rvalid && n < 100) begin
      check("arready_busy", arready, 0);
      @(posedge clk); #1; n++;
    end
    check("rd_latency", n, RD_LAT + 1);
    d0 = rdata; r0 = rresp;
    repeat (rdelay) begin
      @(posedge clk); #1;
      check("rvalid_held", rvalid, 1);
      check("rdata_stable", rdata, d0);
      check("rresp_stable", rresp, r0);
      check("arready_held_low", arready, 0);
    end
    data = d0; resp = r0;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_drop", rvalid, 0);
    check("arready_after_r", arready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, a, v, old, rd_d;
    logic [1:0]  r, wr;
    logic [3:0]  s;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", {awready, wready, arready}, 3'b111);

    // fill memory through the bus
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      v = $urandom;
      axi_write(BASE + 32'(4 * i), v, 4'hF, 0, 0, 0, wr);
      model_write(BASE + 32'(4 * i), v, 4'hF);
      check("init_bresp", wr, 2'b00);
    end

    // word 3 readback, also with low address bits set
    axi_write(BASE + 32'h0C, 32'hDEADBEEF, 4'hF, 0, 0, 0, wr);
    model_write(BASE + 32'h0C, 32'hDEADBEEF, 4'hF);
    axi_read(BASE + 32'h0C, 0, 0, d, r);
    check("rd_word3", d, 32'hDEADBEEF);
    check("rd_word3_resp", r, 2'b00);
    axi_read(BASE + 32'h0F, 0, 0, d, r);
    check("rd_word3_lowbits", d, 32'hDEADBEEF);

    // partial strobe merge
    axi_write(BASE + 32'h10, 32'hAABBCCDD, 4'hF, 0, 0, 0, wr);
    axi_write(BASE + 32'h10, 32'h11223344, 4'b0101, 0, 0, 0, wr);
    check("strb_bresp", wr, 2'b00);
    model_write(BASE + 32'h10, 32'hAABBCCDD, 4'hF);
    model_write(BASE + 32'h10, 32'h11223344, 4'b0101);
    axi_read(BASE + 32'h10, 0, 0, d, r);
    check("strb_merge", d, 32'hAA22CC44);

    // W ahead of AW, then AW ahead of W
    axi_write(BASE + 32'h14, 32'h0BAD_F00D, 4'hF, 2, 0, 1, wr);
    model_write(BASE + 32'h14, 32'h0BAD_F00D, 4'hF);
    axi_read(BASE + 32'h14, 0, 0, d, r);
    check("w_first_data", d, 32'h0BAD_F00D);
    axi_write(BASE + 32'h18, 32'h1234_5678, 4'hF, 0, 3, 0, wr);
    model_write(BASE + 32'h18, 32'h1234_5678, 4'hF);
    axi_read(BASE + 32'h18, 0, 0, d, r);
    check("aw_first_data", d, 32'h1234_5678);

    // out of range just above and just below the window
    a = BASE + 32'(4 * MEM_WORDS);
    axi_read(a, 0, 0, d, r);
    check("oor_hi_rresp", r, 2'b10);
    check("oor_hi_rdata", d, 32'h0);
    axi_write(a, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, wr);
    check("oor_hi_bresp", wr, 2'b10);
    axi_read(BASE, 0, 0, d, r);
    check("oor_hi_no_alias", d, model[0]);
    a = BASE - 32'd4;
    axi_write(a, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, wr);
    check("oor_lo_bresp", wr, 2'b10);
    axi_read(a, 0, 0, d, r);
    check("oor_lo_rresp", r, 2'b10);
    axi_read(BASE + 32'(4 * (MEM_WORDS - 1)), 0, 0, d, r);
    check("oor_lo_no_alias", d, model[MEM_WORDS - 1]);

    // zero strobe is a no-op with OKAY
    axi_write(BASE + 32'h20, 32'h5555_5555, 4'b0000, 0, 0, 0, wr);
    check("strb0_bresp", wr, 2'b00);
    axi_read(BASE + 32'h20, 0, 0, d, r);
    check("strb0_unchanged", d, model[8]);

    // RREADY held off for five cycles
    axi_read(BASE + 32'h0C, 0, 5, d, r);
    check("rdelay_data", d, 32'hDEADBEEF);

    // read sample and write commit land on the same edge
    old = model[7];
    v = ~old;
    fork
      axi_read(BASE + 32'h1C, 0, 0, rd_d, r);
      axi_write(BASE + 32'h1C, v, 4'hF, 1, 1, 0, wr);
    join
    check("collide_old_data", rd_d, old);
    model_write(BASE + 32'h1C, v, 4'hF);
    axi_read(BASE + 32'h1C, 0, 0, d, r);
    check("collide_new_data", d, v);

    // reset while the write is waiting on its latency
    old = model[9];
    awaddr = BASE + 32'h24; wdata = ~old; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    check("pre_reset_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_bvalid", bvalid, 0);
    check("midrst_ready", {awready, wready, arready}, 3'b000);
    check("midrst_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    axi_read(BASE + 32'h24, 0, 0, d, r);
    check("midrst_no_commit", d, old);
    axi_write(BASE + 32'h24, 32'hC0FF_EE00, 4'hF, 0, 0, 2, wr);
    check("post_rst_bresp", wr, 2'b00);
    model_write(BASE + 32'h24, 32'hC0FF_EE00, 4'hF);
    axi_read(BASE + 32'h24, 0, 0, d, r);
    check("post_rst_data", d, 32'hC0FF_EE00);

    // randomized traffic against the model
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) a = BASE + 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 255));
        else                           a = BASE - 32'd4 - 32'(4 * $urandom_range(0, 60));
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, MEM_WORDS - 1)) + 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 0) begin
        v = $urandom;
        s = 4'($urandom_range(0, 15));
        axi_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), wr);
        check("rand_bresp", wr, exp_resp(a));
        model_write(a, v, s);
      end else begin
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3), d, r);
        check("rand_rresp", r, exp_resp(a));
        check("rand_rdata", d, exp_rdata(a));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
